// File: rtl/pbit_gibbs_sampler.sv
// pbit_gibbs_sampler: round-robin (Gibbs) p-bit update engine.
// Holds the N-bit p-bit state, updates one bit per enabled cycle by comparing
// a tanh lookup of the incoming activation against an on-chip 16-bit LFSR.
// Optional feature macro: PBIT_BETA_EN (adds beta_shift activation scaling).
module pbit_gibbs_sampler #(
  parameter int unsigned N    = 4,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [4*N-1:0]           act_flat,
  input  logic [N-1:0]             clamp_mask,
  input  logic [N-1:0]             clamp_val,
`ifdef PBIT_BETA_EN
  input  logic [1:0]               beta_shift,
`endif
  output logic [N-1:0]             state,
  output logic [$clog2(N)-1:0]     idx,
  output logic                     sweep_done,
  output logic [15:0]              sweep_cnt
);

  localparam int unsigned IW        = $clog2(N);
  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  logic [15:0]       lfsr;
  logic [15:0]       lfsr_nxt;
  logic signed [3:0] act_sel;
  logic signed [3:0] act_eff;
  logic signed [7:0] t_val;
  logic signed [7:0] rnd;
  logic              clamp_sel;
  logic              clamp_bit;
  logic              new_bit;
  logic              last;
  logic [N-1:0]      state_nxt;

  // tanh-shaped lookup, odd-symmetric except -8 which saturates to -127
  function automatic logic signed [7:0] tanh_lut(input logic signed [3:0] a);
    logic signed [7:0] r;
    case (a)
      4'sd0:   r = 8'sd0;
      4'sd1:   r = 8'sd59;
      4'sd2:   r = 8'sd97;
      4'sd3:   r = 8'sd115;
      4'sd4:   r = 8'sd122;
      4'sd5:   r = 8'sd125;
      4'sd6:   r = 8'sd126;
      4'sd7:   r = 8'sd127;
      -4'sd1:  r = -8'sd59;
      -4'sd2:  r = -8'sd97;
      -4'sd3:  r = -8'sd115;
      -4'sd4:  r = -8'sd122;
      -4'sd5:  r = -8'sd125;
      -4'sd6:  r = -8'sd126;
      -4'sd7:  r = -8'sd127;
      default: r = -8'sd127;
    endcase
    return r;
  endfunction

  // select the activation and clamp controls of the p-bit being updated
  always_comb begin
    act_sel   = '0;
    clamp_sel = 1'b0;
    clamp_bit = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      if (idx == IW'(k)) begin
        act_sel   = act_flat[4*k +: 4];
        clamp_sel = clamp_mask[k];
        clamp_bit = clamp_val[k];
      end
    end
  end

`ifdef PBIT_BETA_EN
  logic signed [7:0] act_ext;
  logic signed [7:0] act_shl;

  // scale the activation by 2^beta_shift, saturating into the 4-bit range
  always_comb begin
    act_ext = {{4{act_sel[3]}}, act_sel};
    act_shl = act_ext <<< beta_shift;
    if (act_shl > 8'sd7)
      act_eff = 4'sd7;
    else if (act_shl < -8'sd8)
      act_eff = -4'sd8;
    else
      act_eff = act_shl[3:0];
  end
`else
  // no scaling: activation feeds the lookup directly
  always_comb begin
    act_eff = act_sel;
  end
`endif

  // stochastic decision, next state vector, next LFSR value
  always_comb begin
    t_val     = tanh_lut(act_eff);
    rnd       = lfsr[7:0];
    new_bit   = clamp_sel ? clamp_bit : (t_val > rnd);
    last      = (idx == IW'(N - 1));
    lfsr_nxt  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    state_nxt = state;
    for (int k = 0; k < int'(N); k++) begin
      if (idx == IW'(k))
        state_nxt[k] = new_bit;
    end
  end

  // state, sweep position, LFSR and sweep bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= '0;
      idx        <= '0;
      lfsr       <= LFSR_INIT;
      sweep_done <= 1'b0;
      sweep_cnt  <= '0;
    end else if (en) begin
      state      <= state_nxt;
      idx        <= last ? '0 : idx + IW'(1);
      lfsr       <= lfsr_nxt;
      sweep_done <= last;
      if (last)
        sweep_cnt <= sweep_cnt + 16'd1;
    end else begin
      sweep_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pbit_gibbs_sampler.sv
// Testbench for pbit_gibbs_sampler: directed sequence with random activations
// checked against a behavioural model of the sampling rules.
module tb_pbit_gibbs_sampler;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [4*N-1:0] act_flat;
  logic [N-1:0]   clamp_mask;
  logic [N-1:0]   clamp_val;
  logic [N-1:0]   state;
  logic [1:0]     idx;
  logic           sweep_done;
  logic [15:0]    sweep_cnt;
`ifdef PBIT_BETA_EN
  logic [1:0]     beta_shift;
`endif

  // second instance with a fixed seed for the deterministic scenario
  logic           en1;
  logic [4*N-1:0] act1;
  logic [N-1:0]   state1;
  logic [1:0]     idx1;
  logic           done1;
  logic [15:0]    cnt1;

  int tests = 0;
  int fails = 0;

  // reference model of the architectural state
  logic [N-1:0] m_state;
  int           m_idx;
  int           m_cnt;
  logic         m_done;
  logic [15:0]  m_lfsr;

  always #5 clk = ~clk;

  pbit_gibbs_sampler #(.N(N), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .en(en), .act_flat(act_flat),
    .clamp_mask(clamp_mask), .clamp_val(clamp_val),
`ifdef PBIT_BETA_EN
    .beta_shift(beta_shift),
`endif
    .state(state), .idx(idx), .sweep_done(sweep_done), .sweep_cnt(sweep_cnt)
  );

  pbit_gibbs_sampler #(.N(N), .SEED(16'h0001)) dut_s1 (
    .clk(clk), .rst(rst), .en(en1), .act_flat(act1),
    .clamp_mask(4'b0000), .clamp_val(4'b0000),
`ifdef PBIT_BETA_EN
    .beta_shift(2'd0),
`endif
    .state(state1), .idx(idx1), .sweep_done(done1), .sweep_cnt(cnt1)
  );

  function automatic int lut(input int a);
    int pos[8] = '{0, 59, 97, 115, 122, 125, 126, 127};
    if (a >= 0) return pos[a];
    if (a == -8) return -127;
    return -pos[-a];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, 32'(state), 32'(m_state));
    check({tag, ".idx"}, 32'(idx), 32'(m_idx));
    check({tag, ".done"}, 32'(sweep_done), 32'(m_done));
    check({tag, ".cnt"}, 32'(sweep_cnt), 32'(m_cnt));
  endtask

  // one clock with en=e; model advances using the inputs present at the edge
  task automatic step(input logic e, input string tag);
    int a;
    int r;
    logic b;
    en = e;
    @(posedge clk);
    if (e) begin
      a = $signed(act_flat[4*m_idx +: 4]);
      r = $signed(m_lfsr[7:0]);
      b = clamp_mask[m_idx] ? clamp_val[m_idx] : (lut(a) > r);
      m_state[m_idx] = b;
      m_done = (m_idx == N - 1);
      if (m_done) m_cnt = (m_cnt + 1) & 16'hFFFF;
      m_idx = (m_idx + 1) % N;
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end else begin
      m_done = 1'b0;
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    en  = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    m_state = '0;
    m_idx   = 0;
    m_cnt   = 0;
    m_done  = 1'b0;
    m_lfsr  = 16'hACE1;
    check_all("reset");
  endtask

  initial begin
    int ones;
    int p;
    int pulses;
    int pulse_step;
    rst        = 1'b0;
    en         = 1'b0;
    en1        = 1'b0;
    act1       = '0;
    act_flat   = '0;
    clamp_mask = '0;
    clamp_val  = '0;
`ifdef PBIT_BETA_EN
    beta_shift = 2'd0;
`endif

    // reset for two cycles with en high
    act_flat = 16'($urandom);
    do_reset(2);

    // first post-reset rnd is 8'hE1 (-31): t=0 wins, t=-59 loses
    act_flat = 16'h0000;
    step(1'b1, "rnd_e1_a");
    check("rnd_e1_bit0", 32'(state[0]), 32'd1);
    act_flat = 16'hFFFF;
    step(1'b1, "rnd_e1_b");

    // deterministic seed instance: act +1 then 0
    en1  = 1'b1;
    act1 = 16'h1111;
    step(1'b0, "det_idle1");
    check("det_first", 32'(state1), 32'h1);
    act1 = 16'h0000;
    step(1'b0, "det_idle2");
    en1  = 1'b0;
    check("det_second", 32'(state1), 32'h1);
    check("det_idx", 32'(idx1), 32'd2);

    // random activations, random en gaps
    repeat (200) begin
      act_flat = 16'($urandom);
      step(1'($urandom_range(0, 3) != 0), "rand");
    end

    // reset mid-sweep discards the partial sweep
    act_flat = 16'($urandom);
    step(1'b1, "pre_rst");
    do_reset(1);

    // bias: strong positive activation
    act_flat = {N{4'h7}};
    ones = 0;
    repeat (1024) begin
      p = m_idx;
      step(1'b1, "bias_pos");
      ones += int'(state[p]);
    end
    check("bias_pos_count", 32'(ones >= 1015), 32'd1);

    // bias: strong negative activation
    do_reset(1);
    act_flat = {N{4'h8}};
    ones = 0;
    repeat (1024) begin
      p = m_idx;
      step(1'b1, "bias_neg");
      ones += int'(state[p]);
    end
    check("bias_neg_count", 32'(ones <= 9), 32'd1);

    // bias: zero activation is roughly balanced
    do_reset(1);
    act_flat = '0;
    ones = 0;
    repeat (1024) begin
      p = m_idx;
      step(1'b1, "bias_zero");
      ones += int'(state[p]);
    end
    check("bias_zero_count", 32'(ones >= 448 && ones <= 576), 32'd1);

    // clamp bits 0 and 2 with random activations
    do_reset(1);
    clamp_mask = 4'b0101;
    clamp_val  = 4'b0001;
    repeat (N) begin
      act_flat = 16'($urandom);
      step(1'b1, "clamp_sweep");
    end
    check("clamp_b0", 32'(state[0]), 32'd1);
    check("clamp_b2", 32'(state[2]), 32'd0);
    repeat (40) begin
      act_flat = 16'($urandom);
      step(1'($urandom_range(0, 1)), "clamp_hold");
      check("clamp_hold_b0", 32'(state[0]), 32'd1);
      check("clamp_hold_b2", 32'(state[2]), 32'd0);
    end
    clamp_mask = '0;
    clamp_val  = '0;

    // sweep/hold: en = 1,1,0,1,1 then idle
    do_reset(1);
    pulses = 0;
    pulse_step = -1;
    for (int s = 0; s < 6; s++) begin
      logic e;
      e = (s == 2 || s == 5) ? 1'b0 : 1'b1;
      act_flat = 16'($urandom);
      step(e, "sweep");
      if (sweep_done) begin
        pulses++;
        pulse_step = s;
      end
      if (s == 2) check("sweep_idx_hold", 32'(idx), 32'd2);
    end
    check("sweep_pulses", 32'(pulses), 32'd1);
    check("sweep_pulse_pos", 32'(pulse_step), 32'd4);
    check("sweep_cnt_final", 32'(sweep_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pbit_gibbs_sampler.md
# pbit_gibbs_sampler

Sequential p-bit update engine sitting directly downstream of the gate activation modules (COPY/NOT/AND/OR/HA/FA). It holds the N-bit p-bit state vector, whose bits feed those gates' `in` ports. It takes back their 4-bit signed activations and updates one p-bit per enabled cycle in round-robin (Gibbs) order. Each update uses a tanh lookup compared against an on-chip LFSR random number.

## Interface
- `N`, 4: number of p-bits, 2..16.
- `SEED`, 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'hACE1.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous reset, active-high.
- `en` input 1: advance one update step this cycle.
- `act_flat` input 4*N: signed 4-bit activations, p-bit i at `[4i+3:4i]`, driven combinationally from `state`.
- `clamp_mask` input N: 1 forces p-bit i to `clamp_val[i]`.
- `clamp_val` input N: clamp values.
- `beta_shift` input 2: activation left-shift amount. Present only with `PBIT_BETA_EN`.
- `state` output N: p-bit state, 1 = +1, 0 = −1.
- `idx` output $clog2(N): index of the p-bit updated at the next enabled edge.
- `sweep_done` output 1: one-cycle pulse after the last p-bit of a sweep updates.
- `sweep_cnt` output 16: completed sweeps, wraps at 16'hFFFF→0.

## Operation
- Reset values:
  - `state`=0, `idx`=0, `sweep_done`=0, `sweep_cnt`=0.
  - `lfsr`=SEED, or 16'hACE1 when SEED=0.
- LFSR:
  - 16-bit Galois, `lfsr <= {1'b0,lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 0)`.
  - Advances only on cycles with `en`=1.
  - `rnd` = `lfsr[7:0]` as signed 8-bit, taken from the pre-advance value.
- Per enabled cycle, with i=`idx`:
  - a = `act_flat[4i+3:4i]`. With `PBIT_BETA_EN`, a is shifted by `beta_shift`; see Configuration.
  - t = LUT(a), signed 8-bit.
  - Positive entries: LUT(0..7) = 0, 59, 97, 115, 122, 125, 126, 127.
  - Negative entries: LUT(−k) = −LUT(k) for k=1..7, and LUT(−8) = −127.
  - If `clamp_mask[i]`, then `state[i] <= clamp_val[i]`. Otherwise `state[i] <= (t > rnd)`, a signed compare.
  - The LFSR advances even when p-bit i is clamped.
  - `idx` increments; from N−1 it wraps to 0.
- Only `state[idx]` changes per update; all other bits hold.
- Sweep completion: when the updated index is N−1, `sweep_done` is 1 the following cycle and `sweep_cnt` increments.
- `en`=0:
  - `state`, `idx`, `lfsr`, `sweep_cnt` hold.
  - `sweep_done` is 0 from the next cycle.
- Clamp changes take effect on the next update of that index only. A clamped bit is not forced asynchronously.

## Timing
- Activation → state latency: 1 cycle. `act_flat` is sampled at the edge where `en`=1, and `state[idx]` is valid after that edge.
- The external gate network is combinational from `state` to `act_flat`, so the next update sees the new state.
- `sweep_done` is registered: high for exactly one cycle, aligned with `idx`=0 following a wrap.
- One full sweep takes N enabled cycles. Gaps in `en` stretch the sweep without losing position.
- Reset asserted mid-sweep: on that edge all registers return to their reset values, `sweep_done` is 0, and the partial sweep is discarded.
- `rst` has priority over `en`.

## Configuration
- `PBIT_BETA_EN` defined:
  - The `beta_shift` port exists.
  - a = sat(act << `beta_shift`) into [−8, 7] before the LUT. Example: +3 with shift 2 gives +7; −3 with shift 2 gives −8.
- `PBIT_BETA_EN` undefined:
  - The `beta_shift` port is absent.
  - a = act unmodified.

## Test plan
- Reset: assert `rst` 2 cycles with `en`=1 → `state`=0, `idx`=0, `sweep_cnt`=0, `sweep_done`=0, and the first post-reset `rnd`=8'hE1.
- Determinism: SEED=16'h0001, N=4, all activations +1, then 0.
  - First update: rnd=1, LUT(+1)=59 > 1 → `state[0]`=1.
  - `lfsr` becomes 16'hB400.
  - Second update (act 0): rnd=0 → `state[1]`=0.
- Bias: `act_flat` all +7, 1024 enabled cycles → at least 1015 updates produce 1. All −8 → at most 9 updates produce 1. All 0 → 1's count in 448..576.
- Clamp: `clamp_mask`=4'b0101, `clamp_val`=4'b0001, random activations → `state[0]`=1 and `state[2]`=0 after the first sweep, and they remain so.
- Sweep/hold: N=4, `en` toggled 1,1,0,1,1 → `sweep_done` pulses once, one cycle after the 4th enabled edge. `sweep_cnt`=1. `idx` holds during the `en`=0 cycle.
- Beta (`PBIT_BETA_EN`): act +2 with `beta_shift`=2 → saturated a=7, LUT=127, and `state` goes to 1 for rnd ≤ 126. Act −2 with `beta_shift`=3 → a=−8.
